seg7_scan: RTL and testbench

Time-multiplexed driver for an eight-digit, common-anode, seven-segment display. It sits directly downstream of the processor top: it latches a 32-bit value on a load strobe and scans one hex digit per refresh tick. It drives the board's segment and anode pins, `disp_seg_o` and `disp_an_o`, both active-low. It supports per-digit decimal points, whole-display blanking and optional leading-zero suppression.

---
 rtl/seg7_scan.sv | 127 ++++++++++++
 tb/tb_seg7_scan.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for an eight-digit common-anode
// seven-segment display. Latches a 32-bit value on load and shows one hex
// digit per refresh slot, with per-digit decimal points, blanking and
// optional leading-zero suppression. Segment and anode outputs are active-low.
module seg7_scan #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] data_i,
    input  logic        load_i,
    input  logic [7:0]  dp_i,
    input  logic        blank_i,
    input  logic        lzb_i,
    output logic [7:0]  disp_seg_o,
    output logic [7:0]  disp_an_o,
    output logic        frame_o
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;
    logic [2:0]    idx;
    logic [2:0]    nxt;
    logic [31:0]   data_q;
    logic [3:0]    nib;
    logic [2:0]    top;
    logic [6:0]    hex;
    logic [7:0]    seg_d;
    logic [7:0]    an_d;

    assign tick = (cnt == CNT_MAX);
    // Digit about to be selected on the coming tick
    assign nxt  = idx + 3'd1;
    assign nib  = data_q[{nxt, 2'b00} +: 4];

    // Prescaler: one tick every SCAN_DIV cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit index; resets to 7 so the first tick selects digit 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx <= 3'd7;
        end else if (tick) begin
            idx <= nxt;
        end
    end

    // Display register, loaded independently of the scan
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    // Index of the highest nonzero nibble (0 when the value is zero)
    always_comb begin
        top = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (data_q[4*k +: 4] != 4'd0) begin
                top = 3'(k);
            end
        end
    end

    // Hex nibble to segments {g,f,e,d,c,b,a}, active-low
    always_comb begin
        hex = 7'h7F;
        case (nib)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            4'hF: hex = 7'h0E;
            default: hex = 7'h7F;
        endcase
    end

    // Next segment/anode pattern; blanking also suppresses the decimal point
    always_comb begin
        an_d = ~(8'd1 << nxt);
        if (blank_i || (lzb_i && (nxt > top))) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = {~dp_i[nxt], hex};
        end
    end

    // Registered outputs: update on tick, hold between ticks
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_seg_o <= 8'hFF;
            disp_an_o  <= 8'hFF;
            frame_o    <= 1'b0;
        end else begin
            frame_o <= tick && (nxt == 3'd0);
            if (tick) begin
                disp_seg_o <= seg_d;
                disp_an_o  <= an_d;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed bench for seg7_scan with SCAN_DIV=4.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] data_i = '0;
    logic        load_i = 1'b0;
    logic [7:0]  dp_i = '0;
    logic        blank_i = 1'b0;
    logic        lzb_i = 1'b0;
    logic [7:0]  disp_seg_o;
    logic [7:0]  disp_an_o;
    logic        frame_o;

    int n_tests = 0;
    int n_fail  = 0;
    int dig     = 0;

    seg7_scan #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .data_i     (data_i),
        .load_i     (load_i),
        .dp_i       (dp_i),
        .blank_i    (blank_i),
        .lzb_i      (lzb_i),
        .disp_seg_o (disp_seg_o),
        .disp_an_o  (disp_an_o),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // n rising edges, then settle on the following falling edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] v);
        data_i = v;
        load_i = 1'b1;
        cyc(1);
        load_i = 1'b0;
    endtask

    // Check outputs just after a tick that selected digit 'dig'
    task automatic expect_tick(input string tag, input logic [7:0] seg);
        logic [7:0] an;
        an = ~(8'd1 << dig);
        check({tag, ".an"}, {24'd0, disp_an_o}, {24'd0, an});
        check({tag, ".seg"}, {24'd0, disp_seg_o}, {24'd0, seg});
        check({tag, ".frame"}, {31'd0, frame_o}, {31'd0, (dig == 0)});
        dig = (dig + 1) % 8;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst.seg", {24'd0, disp_seg_o}, 32'hFF);
        check("rst.an", {24'd0, disp_an_o}, 32'hFF);
        check("rst.frame", {31'd0, frame_o}, 32'd0);
        @(negedge clk);
        cyc(1);
        rstn = 1'b1;
        dig = 0;
    endtask

    logic [7:0] full_seg [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    logic [7:0] lzb_seg  [8] = '{8'hC0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        #2;
        do_reset();

        // Full scan of 0x89ABCDEF
        load(32'h89ABCDEF);
        cyc(3);
        expect_tick("scan0", full_seg[0]);
        cyc(1);
        check("scan.frame_one_cycle", {31'd0, frame_o}, 32'd0);
        cyc(3);
        expect_tick("scan1", full_seg[1]);
        for (int i = 2; i < 8; i++) begin
            cyc(4);
            expect_tick("scan", full_seg[i]);
        end
        cyc(4);
        expect_tick("scan.wrap", full_seg[0]);

        // Reset mid-scan: dark immediately, restart from reset state
        cyc(2);
        do_reset();
        cyc(3);
        check("rst.no_early_tick", {24'd0, disp_an_o}, 32'hFF);
        cyc(1);
        expect_tick("rst.first", 8'hC0);
        cyc(1);
        check("rst.frame_drop", {31'd0, frame_o}, 32'd0);
        cyc(3);
        expect_tick("rst.d1", 8'hC0);
        for (int i = 2; i < 8; i++) begin
            cyc(4);
            expect_tick("rst.zero", 8'hC0);
        end

        // Leading-zero blanking
        lzb_i = 1'b1;
        load(32'h00000120);
        cyc(3);
        expect_tick("lzb0", lzb_seg[0]);
        for (int i = 1; i < 8; i++) begin
            cyc(4);
            expect_tick("lzb", lzb_seg[i]);
        end
        load(32'h0);
        cyc(3);
        expect_tick("lzb.zero0", 8'hC0);
        for (int i = 1; i < 8; i++) begin
            cyc(4);
            expect_tick("lzb.zero", 8'hFF);
        end

        // Decimal point on digit 2
        lzb_i = 1'b0;
        dp_i = 8'h04;
        for (int i = 0; i < 8; i++) begin
            cyc(4);
            expect_tick("dp", (i == 2) ? 8'h40 : 8'hC0);
        end

        // Load coinciding with a tick uses the old value
        dp_i = 8'h00;
        load(32'h11111111);
        cyc(2);
        data_i = 32'h22222222;
        load_i = 1'b1;
        cyc(1);
        load_i = 1'b0;
        expect_tick("coll.old", 8'hF9);
        cyc(4);
        expect_tick("coll.new", 8'hA4);

        // Blank keeps anodes cycling
        blank_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(4);
            expect_tick("blank", 8'hFF);
        end
        blank_i = 1'b0;
        cyc(4);
        expect_tick("unblank", 8'hA4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
